eth_tx_arb: RTL

- Round-robin arbiter and sequencer that shares the single RMII transmit path (tx control FSM plus its FIFO) between NUM_REQ frame sources, e.g. the ARP responder and the UDP frame builder.
- Grants one requester at a time and issues the one-cycle Eth_Pkt_Rdy start pulse to the tx control FSM.
- Tracks frame start and end through Tx_En, enforces the inter-frame gap, and supervises start and frame-length timeouts.

---
 rtl/eth_tx_arb.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/eth_tx_arb.sv
// Round-robin arbiter and start sequencer for the shared RMII transmit path.
// It grants one frame source at a time and pulses Eth_Pkt_Rdy to the tx control FSM.
// It follows the frame through Tx_En, enforces the inter-frame gap, and
// supervises both the start timeout and the frame-length overrun.
module eth_tx_arb #(
    parameter int unsigned NUM_REQ          = 2,
    parameter int unsigned IFG_CYCLES       = 48,
    parameter int unsigned START_TIMEOUT    = 16,
    parameter int unsigned MAX_FRAME_CYCLES = 6144
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic [NUM_REQ-1:0] Req,
    output logic [NUM_REQ-1:0] Gnt,
    output logic [NUM_REQ-1:0] Done,
    output logic               Err,
    output logic               Eth_Pkt_Rdy,
    input  logic               Tx_En,
    output logic               Busy,
    output logic [2:0]         Arb_State
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned TO_W  = $clog2(START_TIMEOUT) + 1;
    localparam int unsigned FR_W  = $clog2(MAX_FRAME_CYCLES) + 1;
    localparam int unsigned IFG_W = $clog2(IFG_CYCLES) + 1;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TIMEOUT - 1);
    localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(MAX_FRAME_CYCLES - 1);
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_GRANT      = 3'd1;
    localparam logic [2:0] ST_WAIT_START = 3'd2;
    localparam logic [2:0] ST_ACTIVE     = 3'd3;
    localparam logic [2:0] ST_IFG        = 3'd4;

    logic [2:0]         state,      state_nx;
    logic [PTR_W-1:0]   ptr,        ptr_nx;
    logic [TO_W-1:0]    to_cnt,     to_cnt_nx;
    logic [FR_W-1:0]    fr_cnt,     fr_cnt_nx;
    logic [IFG_W-1:0]   ifg_cnt,    ifg_cnt_nx;
    logic [NUM_REQ-1:0] gnt_nx;
    logic [NUM_REQ-1:0] done_nx;
    logic               err_nx;
    logic               rdy_nx;
    logic               busy_nx;
    logic [PTR_W-1:0]   win_c;

    // First requester at or above the pointer, wrapping modulo NUM_REQ.
    // The loop runs downward so that the lowest offset writes win last.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [PTR_W-1:0]   start);
        logic [PTR_W-1:0] win;
        int unsigned      idx;
        win = start;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (32'(start) + 32'(i)) % NUM_REQ;
            if (req[PTR_W'(idx)]) begin
                win = PTR_W'(idx);
            end
        end
        return win;
    endfunction

    assign win_c     = rr_pick(Req, ptr);
    assign Arb_State = state;

    // Next-state, counter and output decode
    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        to_cnt_nx  = to_cnt;
        fr_cnt_nx  = fr_cnt;
        ifg_cnt_nx = ifg_cnt;
        gnt_nx     = Gnt;
        done_nx    = '0;
        err_nx     = 1'b0;
        rdy_nx     = 1'b0;

        case (state)
            ST_IDLE: begin
                gnt_nx = '0;
                if (|Req) begin
                    gnt_nx   = NUM_REQ'(1) << win_c;
                    ptr_nx   = PTR_W'((32'(win_c) + 32'd1) % NUM_REQ);
                    rdy_nx   = 1'b1;
                    state_nx = ST_GRANT;
                end
            end
            ST_GRANT: begin
                to_cnt_nx = '0;
                state_nx  = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (Tx_En) begin
                    fr_cnt_nx = '0;
                    state_nx  = ST_ACTIVE;
                end else if (to_cnt == TO_LAST) begin
                    err_nx     = 1'b1;
                    gnt_nx     = '0;
                    ifg_cnt_nx = '0;
                    state_nx   = ST_IFG;
                end else if (to_cnt != '1) begin
                    to_cnt_nx = to_cnt + TO_W'(1);
                end
            end
            ST_ACTIVE: begin
                // A Tx_En fall takes priority over an overrun on the same cycle.
                if (!Tx_En) begin
                    done_nx    = Gnt;
                    gnt_nx     = '0;
                    ifg_cnt_nx = '0;
                    state_nx   = ST_IFG;
                end else if (fr_cnt == FR_LAST) begin
                    err_nx     = 1'b1;
                    gnt_nx     = '0;
                    ifg_cnt_nx = '0;
                    state_nx   = ST_IFG;
                end else if (fr_cnt != '1) begin
                    fr_cnt_nx = fr_cnt + FR_W'(1);
                end
            end
            ST_IFG: begin
                // After an overrun the tx FSM may still be sending; the gap only runs once it stops.
                if (Tx_En) begin
                    ifg_cnt_nx = '0;
                end else if (ifg_cnt == IFG_LAST) begin
                    ifg_cnt_nx = '0;
                    state_nx   = ST_IDLE;
                end else if (ifg_cnt != '1) begin
                    ifg_cnt_nx = ifg_cnt + IFG_W'(1);
                end
            end
            default: begin
                gnt_nx   = '0;
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

    // State, counter and output registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            to_cnt      <= '0;
            fr_cnt      <= '0;
            ifg_cnt     <= '0;
            Gnt         <= '0;
            Done        <= '0;
            Err         <= 1'b0;
            Eth_Pkt_Rdy <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            to_cnt      <= to_cnt_nx;
            fr_cnt      <= fr_cnt_nx;
            ifg_cnt     <= ifg_cnt_nx;
            Gnt         <= gnt_nx;
            Done        <= done_nx;
            Err         <= err_nx;
            Eth_Pkt_Rdy <= rdy_nx;
            Busy        <= busy_nx;
        end
    end

endmodule
